npu_sched: RTL and testbench
============================

NPU_SCHED -- requirements
Module: npu_sched

Interface
REQ-001 SHALL take parameter NCORE, default 4: number of NPU cores scheduled.
REQ-002 SHALL take parameter QDEP, default 4: job queue depth in entries, power of two.
REQ-003 SHALL have one clock and a synchronous active-high reset; all state changes on the aclk rising edge.
REQ-004 aclk  in  1  system clock.
REQ-005 arst  in  1  synchronous active-high reset.
REQ-006 en  in  1  dispatch enable.
REQ-007 job_vld  in  1  job request valid.
REQ-008 job_rdy  out  1  job request ready.
REQ-009 job_ofs  in  32  job memory offset.
REQ-010 job_siz  in  32  job size.
REQ-011 slv_ofs  out  32  offset presented to the cores.
REQ-012 slv_siz  out  32  size presented to the cores.
REQ-013 slv_stt  out  NCORE  per-core one-cycle start pulse.
REQ-014 slv_fin  in  NCORE  per-core one-cycle finish pulse.
REQ-015 slv_bsy  in  NCORE  per-core busy level.
REQ-016 q_cnt  out  3  queued job count, 0..QDEP.
REQ-017 done_cnt  out  16  completed-job counter.
REQ-018 irq  out  1  sticky completion interrupt.
REQ-019 irq_clr  in  1  interrupt clear pulse.
REQ-020 err  out  1  sticky flag for an unexpected finish.

Function
REQ-021 Queue SHALL be a QDEP-entry FIFO; push when job_vld & job_rdy; job_rdy = (q_cnt != QDEP), with no push at full even if a pop occurs in the same cycle.
REQ-022 Simultaneous push and pop SHALL leave q_cnt unchanged and preserve FIFO order; pointers wrap modulo QDEP.
REQ-023 Core i is free when own[i]=0 and slv_bsy[i]=0; own[i] is an internal "job issued, not finished" bit.
REQ-024 FSM states SHALL be IDLE, ISSUE and GAP.
REQ-025 IDLE->ISSUE transition: en=1, q_cnt>0 and at least one free core. Actions: select the first free core searching from rr_ptr upward, modulo NCORE; pop the head; register slv_ofs/slv_siz from the head; latch sel.
REQ-026 ISSUE: slv_stt[sel]=1 for exactly one cycle; set own[sel]; rr_ptr <= sel+1 mod NCORE; next state GAP.
REQ-027 GAP: one cycle, no issue, then IDLE; minimum issue-to-issue spacing is 3 cycles.
REQ-028 slv_ofs/slv_siz SHALL hold their values from ISSUE until the next IDLE->ISSUE transition.
REQ-029 Latency: job pushed at cycle T into an empty queue with a free core and en=1 -> slv_stt asserted at T+2.
REQ-030 en=0 SHALL block new IDLE->ISSUE transitions only; a dispatch already in ISSUE/GAP completes, and the queue keeps accepting pushes.
REQ-031 slv_fin[i] with own[i]=1 SHALL clear own[i], add 1 to done_cnt and set irq.
REQ-032 slv_fin[i] with own[i]=0 SHALL set err and change nothing else.
REQ-033 Multiple owned finishes in one cycle SHALL add their popcount to done_cnt; done_cnt saturates at 0xFFFF.
REQ-034 irq SHALL stay set until irq_clr; set wins over a simultaneous irq_clr; err is cleared only by reset.
REQ-035 slv_stt SHALL be one-hot or zero in every cycle.

Reset
REQ-036 While arst=1, the following SHALL all be 0: slv_ofs, slv_siz, slv_stt, q_cnt, done_cnt, irq, err, job_rdy, own, rr_ptr.
REQ-037 While arst=1, the FSM SHALL be held in IDLE; job_rdy=1 from the first cycle after arst deasserts.
REQ-038 Reset mid-operation SHALL drop queued and in-flight jobs without a slv_stt pulse; a slv_fin arriving after reset sets err.

Verification
REQ-039 Reset, en=1, push ofs=0x1000 siz=0x40 at cycle T -> slv_stt=4'b0001 at T+2 with slv_ofs=0x1000, slv_siz=0x40; q_cnt back to 0.
REQ-040 Push 5 jobs back-to-back, no finish, en=0 -> 4 accepted, job_rdy=0, q_cnt=4; set en=1 -> slv_stt order 0001,0010,0100,1000 spaced 3 cycles, q_cnt=0.
REQ-041 With all own=1, pulse slv_fin=4'b0101 -> done_cnt +2, irq=1; with slv_bsy=0, next job goes to core 0 (rr_ptr=0 after core 3).
REQ-042 slv_bsy[1]=1 externally, rr_ptr=1, one job queued -> dispatch to core 2.
REQ-043 slv_fin[3] with own[3]=0 -> err=1, done_cnt unchanged; irq_clr concurrent with an owned finish -> irq stays 1.
REQ-044 Assert arst during GAP with 2 jobs queued -> q_cnt=0, own=0, no further slv_stt after release.

Source files
------------

// File: rtl/npu_sched_if.sv
// Job request and core dispatch signals of the NPU scheduler.
// The slave modport is the scheduler side; the master modport drives jobs and core status.
interface npu_sched_if #(
  parameter int NCORE = 4
);
  logic             job_vld;
  logic             job_rdy;
  logic [31:0]      job_ofs;
  logic [31:0]      job_siz;
  logic [31:0]      slv_ofs;
  logic [31:0]      slv_siz;
  logic [NCORE-1:0] slv_stt;
  logic [NCORE-1:0] slv_fin;
  logic [NCORE-1:0] slv_bsy;

  modport master (
    output job_vld, job_ofs, job_siz, slv_fin, slv_bsy,
    input  job_rdy, slv_ofs, slv_siz, slv_stt
  );

  modport slave (
    input  job_vld, job_ofs, job_siz, slv_fin, slv_bsy,
    output job_rdy, slv_ofs, slv_siz, slv_stt
  );
endinterface

// File: rtl/npu_sched.sv
// Job FIFO plus round-robin dispatcher to NCORE NPU cores, with completion
// counting, sticky completion interrupt and sticky unexpected-finish error.
module npu_sched #(
  parameter int NCORE = 4,
  parameter int QDEP  = 4
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic        en,
  npu_sched_if.slave  bus,
  output logic [2:0]  q_cnt,
  output logic [15:0] done_cnt,
  output logic        irq,
  input  logic        irq_clr,
  output logic        err
);
  localparam int PW = (NCORE > 1) ? $clog2(NCORE) : 1;
  localparam int AW = (QDEP > 1) ? $clog2(QDEP) : 1;
  localparam int CW = $clog2(QDEP) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [7:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {9'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [31:0]      mem_ofs [QDEP];
  logic [31:0]      mem_siz [QDEP];
  logic [NCORE-1:0] own, free, own_fin, bad_fin, issue_mask;
  logic [PW-1:0]    rr_ptr, sel_q, pick;
  logic             found, push, pop;
  logic [7:0]       fin_n;
  int               idx;

  assign bus.job_rdy = !arst && (cnt != CW'(QDEP));
  assign push        = bus.job_vld && bus.job_rdy;
  assign q_cnt       = 3'(cnt);
  assign free        = ~own & ~bus.slv_bsy;
  assign own_fin     = bus.slv_fin & own;
  assign bad_fin     = bus.slv_fin & ~own;
  assign issue_mask  = {{(NCORE-1){1'b0}}, 1'b1} << sel_q;
  assign bus.slv_stt = (state_q == ISSUE && !arst) ? issue_mask : '0;

  // First free core at or above rr_ptr, wrapping modulo NCORE
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NCORE; k++) begin
      idx = (int'(rr_ptr) + k) % NCORE;
      if (!found && free[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  always_comb begin
    fin_n = '0;
    for (int i = 0; i < NCORE; i++) fin_n = fin_n + {7'd0, own_fin[i]};
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (en && cnt != '0 && found) begin
        state_d = ISSUE;
        pop     = 1'b1;
      end
      ISSUE:   state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q     <= IDLE;
      cnt         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      own         <= '0;
      rr_ptr      <= '0;
      sel_q       <= '0;
      bus.slv_ofs <= '0;
      bus.slv_siz <= '0;
      done_cnt    <= '0;
      irq         <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q <= state_d;
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr      <= rd_ptr + AW'(1);
        sel_q       <= pick;
        bus.slv_ofs <= mem_ofs[rd_ptr];
        bus.slv_siz <= mem_siz[rd_ptr];
      end
      if (state_q == ISSUE)
        rr_ptr <= (sel_q == PW'(NCORE - 1)) ? '0 : sel_q + PW'(1);
      // Finish clears ownership before the issue bit is merged in
      own      <= (own & ~own_fin) | ((state_q == ISSUE) ? issue_mask : '0);
      done_cnt <= sat_add16(done_cnt, fin_n);
      irq      <= (irq && !irq_clr) || (own_fin != '0);
      err      <= err || (bad_fin != '0);
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_ofs[wr_ptr] <= bus.job_ofs;
      mem_siz[wr_ptr] <= bus.job_siz;
    end
  end
endmodule

// File: tb/tb_npu_sched.sv
// Self-checking bench for npu_sched: a job scoreboard follows accepted pushes
// and is popped on every slv_stt pulse together with the expected core.
module tb_npu_sched;
  typedef struct packed {
    logic [31:0] ofs;
    logic [31:0] siz;
  } job_t;

  logic        aclk, arst, en, irq_clr;
  logic [2:0]  q_cnt;
  logic [15:0] done_cnt;
  logic        irq, err;

  npu_sched_if #(.NCORE(4)) bus ();

  npu_sched #(.NCORE(4), .QDEP(4)) dut (
    .aclk     (aclk),
    .arst     (arst),
    .en       (en),
    .bus      (bus.slave),
    .q_cnt    (q_cnt),
    .done_cnt (done_cnt),
    .irq      (irq),
    .irq_clr  (irq_clr),
    .err      (err)
  );

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  job_t exp_q[$];
  int   core_q[$];
  int   mon_core;
  job_t mon_job;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    tick();
    tick();
    arst = 1'b0;
    exp_q.delete();
    core_q.delete();
    tick();
  endtask

  task automatic wait_stt(output int c);
    c = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.slv_stt != '0) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("stt_timeout", 32'd1, 32'd0);
  endtask

  task automatic push_one(input logic [31:0] o, input logic [31:0] s);
    bus.job_vld = 1'b1;
    bus.job_ofs = o;
    bus.job_siz = s;
    tick();
    bus.job_vld = 1'b0;
  endtask

  task automatic pulse_fin(input logic [3:0] f);
    bus.slv_fin = f;
    tick();
    bus.slv_fin = '0;
  endtask

  // Scoreboard: pop on each start pulse, then record an accepted push
  always @(negedge aclk) begin
    if (bus.slv_stt != '0) begin
      chk("stt_onehot", 32'($onehot(bus.slv_stt)), 32'd1);
      if (core_q.size() == 0 || exp_q.size() == 0) begin
        chk("stt_unexpected", 32'(bus.slv_stt), 32'd0);
      end else begin
        mon_core = core_q.pop_front();
        mon_job  = exp_q.pop_front();
        chk("stt_core", 32'(bus.slv_stt), 32'd1 << mon_core);
        chk("slv_ofs", bus.slv_ofs, mon_job.ofs);
        chk("slv_siz", bus.slv_siz, mon_job.siz);
      end
    end
    if (bus.job_vld && bus.job_rdy && !arst)
      exp_q.push_back('{ofs: bus.job_ofs, siz: bus.job_siz});
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0, c1, n;
    arst = 1'b1; en = 1'b0; irq_clr = 1'b0;
    bus.job_vld = 1'b0; bus.job_ofs = '0; bus.job_siz = '0;
    bus.slv_fin = '0; bus.slv_bsy = '0;
    tick(); tick();
    chk("rst_q_cnt", 32'(q_cnt), 32'd0);
    chk("rst_done", 32'(done_cnt), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdy", 32'(bus.job_rdy), 32'd0);
    chk("rst_stt", 32'(bus.slv_stt), 32'd0);
    chk("rst_ofs", bus.slv_ofs, 32'd0);
    chk("rst_siz", bus.slv_siz, 32'd0);
    arst = 1'b0;
    tick();
    chk("rdy_after_rst", 32'(bus.job_rdy), 32'd1);

    // Single job latency
    en = 1'b1;
    core_q.push_back(0);
    push_one(32'h1000, 32'h40);
    chk("lat_t1_stt", 32'(bus.slv_stt), 32'd0);
    tick();
    chk("lat_t2_stt", 32'(bus.slv_stt), 32'd1);
    chk("lat_t2_ofs", bus.slv_ofs, 32'h1000);
    chk("lat_t2_siz", bus.slv_siz, 32'h40);
    chk("lat_q_cnt", 32'(q_cnt), 32'd0);
    tick(); tick();
    pulse_fin(4'b0001);
    chk("fin0_done", 32'(done_cnt), 32'd1);
    chk("fin0_irq", 32'(irq), 32'd1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("irq_cleared", 32'(irq), 32'd0);

    // Fill queue with dispatch disabled, then release in round-robin order
    do_reset();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("rdy_full", 32'(bus.job_rdy), 32'd0);
      bus.job_vld = 1'b1;
      bus.job_ofs = 32'h2000 + 32'(i) * 32'h100;
      bus.job_siz = 32'(i + 1);
      tick();
    end
    bus.job_vld = 1'b0;
    chk("full_q_cnt", 32'(q_cnt), 32'd4);
    chk("full_rdy", 32'(bus.job_rdy), 32'd0);
    chk("full_no_stt", 32'(bus.slv_stt), 32'd0);
    for (int i = 0; i < 4; i++) core_q.push_back(i);
    en = 1'b1;
    c0 = -1;
    for (int i = 0; i < 4; i++) begin
      wait_stt(c1);
      chk("rr_stt", 32'(bus.slv_stt), 32'd1 << i);
      if (i > 0) chk("rr_spacing", 32'(c1 - c0), 32'd3);
      c0 = c1;
    end
    tick(); tick();
    chk("rr_q_cnt", 32'(q_cnt), 32'd0);
    chk("rr_err", 32'(err), 32'd0);

    // Two owned finishes at once; next job wraps to core 0
    pulse_fin(4'b0101);
    chk("fin2_done", 32'(done_cnt), 32'd2);
    chk("fin2_irq", 32'(irq), 32'd1);
    core_q.push_back(0);
    push_one(32'h3000, 32'h80);
    wait_stt(c1);
    chk("wrap_stt", 32'(bus.slv_stt), 32'b0001);
    tick(); tick();

    // Owned finish beats irq_clr; unowned finish sets err only
    bus.slv_fin = 4'b1000;
    irq_clr = 1'b1;
    tick();
    bus.slv_fin = '0;
    irq_clr = 1'b0;
    chk("setwins_irq", 32'(irq), 32'd1);
    chk("setwins_done", 32'(done_cnt), 32'd3);
    chk("pre_err", 32'(err), 32'd0);
    pulse_fin(4'b1000);
    chk("bad_fin_err", 32'(err), 32'd1);
    chk("bad_fin_done", 32'(done_cnt), 32'd3);
    pulse_fin(4'b0011);
    chk("fin_clear_done", 32'(done_cnt), 32'd5);

    // Externally busy core 1 is skipped from rr_ptr=1
    bus.slv_bsy = 4'b0010;
    core_q.push_back(2);
    push_one(32'h4000, 32'hC0);
    wait_stt(c1);
    chk("bsy_stt", 32'(bus.slv_stt), 32'b0100);
    tick(); tick();
    bus.slv_bsy = '0;

    // Reset during GAP drops queued jobs and ownership
    en = 1'b0;
    for (int i = 0; i < 3; i++) push_one(32'h5000 + 32'(i), 32'h10);
    chk("pre_rst_q", 32'(q_cnt), 32'd3);
    core_q.push_back(3);
    en = 1'b1;
    wait_stt(c1);
    chk("pre_rst_stt", 32'(bus.slv_stt), 32'b1000);
    tick();
    chk("gap_q_cnt", 32'(q_cnt), 32'd2);
    do_reset();
    chk("post_rst_q", 32'(q_cnt), 32'd0);
    chk("post_rst_done", 32'(done_cnt), 32'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.slv_stt != '0) n++;
      tick();
    end
    chk("post_rst_no_stt", 32'(n), 32'd0);
    pulse_fin(4'b1000);
    chk("post_rst_err", 32'(err), 32'd1);
    chk("post_rst_fin_done", 32'(done_cnt), 32'd0);
    chk("post_rst_irq", 32'(irq), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
